// File: rtl/kia_ps2_queue.sv
// kia_ps2_queue: PS/2 receiver with scan-code FIFO and 8-bit bus slave.
// Define KIA_PARITY_CHECK_EN to drop odd-parity failures and report PERR.
module kia_ps2_queue #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter logic [15:0] TIMEOUT    = 16'd50000
) (
    input  logic       CLK_I,
    input  logic       RES_I,
    input  logic [1:0] ADR_I,
    input  logic       WE_I,
    input  logic       CYC_I,
    input  logic       STB_I,
    input  logic [7:0] DAT_I,
    output logic       ACK_O,
    output logic [7:0] DAT_O,
    output logic       INT_O,
    input  logic       D_I,
    input  logic       C_I
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PAR,
        S_STOP
    } rx_t;

    logic c_s1_q, c_s2_q, c_s3_q;
    logic d_s1_q, d_s2_q;
    logic c_fall;

    rx_t         st_q;
    logic [2:0]  bit_q;
    logic [7:0]  sh_q;
    logic [15:0] tmo_q;
    logic        par_bad;

    logic [PW-1:0] wp_q, rp_q;
    logic [PW-1:0] fill;
    logic [7:0]    mem_q [DEPTH];
    logic          empty, full;

    logic       ack_q, ack_d;
    logic [7:0] dat_q, rd;
    logic       acc_we_q;
    logic [1:0] acc_adr_q;
    logic [1:0] acc_dat_q;
    logic       ie_q, int_q;
    logic       ovf_q, ferr_q, perr_q;

    logic at_stop, stop_err, perr_set, push_req, tmo_hit;
    logic ferr_set, ovf_set, push, pop, bus_wr, clr;
    logic unused_dat;

    assign unused_dat = ^DAT_I[7:2];

    always_ff @(posedge CLK_I or negedge RES_I) begin
        if (!RES_I) begin
            c_s1_q <= 1'b1;
            c_s2_q <= 1'b1;
            c_s3_q <= 1'b1;
            d_s1_q <= 1'b1;
            d_s2_q <= 1'b1;
        end else begin
            c_s1_q <= C_I;
            c_s2_q <= c_s1_q;
            c_s3_q <= c_s2_q;
            d_s1_q <= D_I;
            d_s2_q <= d_s1_q;
        end
    end

    assign c_fall = c_s3_q & ~c_s2_q;

`ifdef KIA_PARITY_CHECK_EN
    logic par_q;
    assign par_bad = ~(^{par_q, sh_q});
`else
    assign par_bad = 1'b0;
`endif

    assign at_stop  = c_fall & (st_q == S_STOP);
    assign stop_err = at_stop & ~d_s2_q;
    assign perr_set = at_stop & d_s2_q & par_bad;
    assign push_req = at_stop & d_s2_q & ~par_bad;
    assign tmo_hit  = ~c_fall & (st_q != S_IDLE) & (tmo_q == TIMEOUT);
    assign ferr_set = stop_err | tmo_hit;

    always_ff @(posedge CLK_I or negedge RES_I) begin
        if (!RES_I) begin
            st_q  <= S_IDLE;
            bit_q <= '0;
            sh_q  <= '0;
            tmo_q <= '0;
`ifdef KIA_PARITY_CHECK_EN
            par_q <= 1'b0;
`endif
        end else if (c_fall) begin
            tmo_q <= '0;
            unique case (st_q)
                S_IDLE: begin
                    if (!d_s2_q) begin
                        st_q  <= S_DATA;
                        bit_q <= '0;
                    end
                end
                S_DATA: begin
                    sh_q  <= {d_s2_q, sh_q[7:1]};
                    bit_q <= bit_q + 3'd1;
                    if (bit_q == 3'd7) st_q <= S_PAR;
                end
                S_PAR: begin
`ifdef KIA_PARITY_CHECK_EN
                    par_q <= d_s2_q;
`endif
                    st_q <= S_STOP;
                end
                S_STOP: st_q <= S_IDLE;
                default: st_q <= S_IDLE;
            endcase
        end else if (st_q == S_IDLE) begin
            tmo_q <= '0;
        end else if (tmo_hit) begin
            // stalled device: abandon the partial frame
            st_q  <= S_IDLE;
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 16'd1;
        end
    end

    assign empty = (wp_q == rp_q);
    assign full  = (wp_q[DEPTH_LOG2-1:0] == rp_q[DEPTH_LOG2-1:0])
                 & (wp_q[PW-1] != rp_q[PW-1]);
    assign fill  = wp_q - rp_q;

    assign bus_wr  = ack_q & acc_we_q;
    assign pop     = bus_wr & (acc_adr_q == 2'd1) & ~empty;
    assign clr     = bus_wr & (acc_adr_q == 2'd2) & acc_dat_q[1];
    assign push    = push_req & (~full | pop);
    assign ovf_set = push_req & full & ~pop;

    always_ff @(posedge CLK_I or negedge RES_I) begin
        if (!RES_I) begin
            wp_q <= '0;
            rp_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wp_q[DEPTH_LOG2-1:0]] <= sh_q;
                wp_q <= wp_q + 1'b1;
            end
            if (pop) rp_q <= rp_q + 1'b1;
        end
    end

    always_comb begin
        rd = '0;
        unique case (ADR_I)
            2'd0: rd = {2'b00, ie_q & ~empty, perr_q, ferr_q,
                        ovf_q, full, empty};
            2'd1: rd = mem_q[rp_q[DEPTH_LOG2-1:0]];
            2'd2: rd = {7'b0, ie_q};
            2'd3: rd = 8'(fill);
            default: rd = '0;
        endcase
    end

    assign ack_d = CYC_I & STB_I & ~ack_q;

    // Requests are latched at the strobe edge and committed at ACK end.
    always_ff @(posedge CLK_I or negedge RES_I) begin
        if (!RES_I) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            acc_we_q  <= 1'b0;
            acc_adr_q <= '0;
            acc_dat_q <= '0;
            ie_q      <= 1'b0;
            int_q     <= 1'b0;
            ovf_q     <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            ack_q <= ack_d;
            if (ack_d) begin
                acc_we_q  <= WE_I;
                acc_adr_q <= ADR_I;
                acc_dat_q <= DAT_I[1:0];
                dat_q     <= rd;
            end else begin
                dat_q <= '0;
            end
            if (bus_wr && acc_adr_q == 2'd2) ie_q <= acc_dat_q[0];
            int_q  <= ie_q & ~empty;
            ovf_q  <= ovf_set  | (ovf_q  & ~clr);
            ferr_q <= ferr_set | (ferr_q & ~clr);
            perr_q <= perr_set | (perr_q & ~clr);
        end
    end

    assign ACK_O = ack_q;
    assign DAT_O = dat_q;
    assign INT_O = int_q;

endmodule

// File: tb/tb_kia_ps2_queue.sv
// tb_kia_ps2_queue: directed and random PS/2 frames and bus accesses
// against a queue-based model of the adapter.
module tb_kia_ps2_queue;

    localparam int DL   = 2;
    localparam int CAP  = 4;
    localparam int TMO  = 200;
    localparam int HALF = 10;
`ifdef KIA_PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    logic       CLK_I = 1'b0;
    logic       RES_I = 1'b0;
    logic [1:0] ADR_I = '0;
    logic       WE_I  = 1'b0;
    logic       CYC_I = 1'b0;
    logic       STB_I = 1'b0;
    logic [7:0] DAT_I = '0;
    logic       ACK_O;
    logic [7:0] DAT_O;
    logic       INT_O;
    logic       D_I   = 1'b1;
    logic       C_I   = 1'b1;

    always #5 CLK_I = ~CLK_I;

    kia_ps2_queue #(
        .DEPTH_LOG2(DL),
        .TIMEOUT(16'(TMO))
    ) dut (
        .CLK_I(CLK_I),
        .RES_I(RES_I),
        .ADR_I(ADR_I),
        .WE_I(WE_I),
        .CYC_I(CYC_I),
        .STB_I(STB_I),
        .DAT_I(DAT_I),
        .ACK_O(ACK_O),
        .DAT_O(DAT_O),
        .INT_O(INT_O),
        .D_I(D_I),
        .C_I(C_I)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit busy   = 1'b1;

    logic [7:0] mq[$];
    bit m_ie, m_ovf, m_ferr, m_perr;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_exp(input logic [1:0] adr);
        logic [7:0] s;
        s = '0;
        case (adr)
            2'd0: begin
                s[0] = (mq.size() == 0);
                s[1] = (mq.size() == CAP);
                s[2] = m_ovf;
                s[3] = m_ferr;
                s[4] = m_perr;
                s[5] = m_ie && (mq.size() != 0);
            end
            2'd1: s = mq[0];
            2'd2: s[0] = m_ie;
            default: s = 8'(mq.size());
        endcase
        return s;
    endfunction

    task automatic bus(input bit we, input logic [1:0] adr,
                       input logic [7:0] wd, output logic [7:0] rdat);
        @(negedge CLK_I);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = wd;
        @(posedge CLK_I); #1;
        chk("ack_rise", {7'b0, ACK_O}, 8'h01);
        rdat = DAT_O;
        @(posedge CLK_I); #1;
        chk("ack_fall", {7'b0, ACK_O}, 8'h00);
        @(negedge CLK_I);
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    endtask

    task automatic rd_m(input logic [1:0] adr, input string nm);
        logic [7:0] r;
        bus(1'b0, adr, 8'h00, r);
        if (!(adr == 2'd1 && mq.size() == 0)) chk(nm, r, m_exp(adr));
    endtask

    task automatic rd_lit(input logic [1:0] adr, input string nm,
                          input logic [7:0] val);
        logic [7:0] r;
        bus(1'b0, adr, 8'h00, r);
        chk(nm, r, val);
    endtask

    task automatic wr(input logic [1:0] adr, input logic [7:0] d);
        logic [7:0] r;
        busy = 1'b1;
        bus(1'b1, adr, d, r);
        if (adr == 2'd1 && mq.size() > 0) r = mq.pop_front();
        if (adr == 2'd2) begin
            m_ie = d[0];
            if (d[1]) begin
                m_ovf = 0; m_ferr = 0; m_perr = 0;
            end
        end
        busy = 1'b0;
    endtask

    // cut>0: stop clocking after that many data bits, then idle past TIMEOUT
    task automatic send(input logic [7:0] b, input bit bpar,
                        input bit bstop, input int cut, input bit popf);
        logic [10:0] fr;
        logic [7:0]  r;
        busy = 1'b1;
        fr = {~bstop, (~^b) ^ bpar, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (cut > 0 && i == cut + 1) break;
            @(negedge CLK_I);
            D_I = fr[i];
            repeat (HALF) @(negedge CLK_I);
            C_I = 1'b0;
            if (i == 10 && popf) bus(1'b1, 2'd1, 8'(($urandom)), r);
            repeat (HALF) @(negedge CLK_I);
            C_I = 1'b1;
        end
        D_I = 1'b1;
        if (cut > 0) repeat (TMO + 5) @(negedge CLK_I);
        else repeat (8) @(negedge CLK_I);
        if (popf && cut == 0 && mq.size() > 0) r = mq.pop_front();
        if (cut > 0 || bstop) m_ferr = 1;
        else if (bpar && PCHK) m_perr = 1;
        else if (mq.size() < CAP) mq.push_back(b);
        else m_ovf = 1;
        busy = 1'b0;
    endtask

    task automatic monitor();
        int idle = 0;
        forever begin
            @(negedge CLK_I);
            if (!ACK_O) chk("dat_idle", DAT_O, 8'h00);
            if (busy) idle = 0;
            else if (idle < 3) idle++;
            else chk("int_o", {7'b0, INT_O},
                     {7'b0, m_ie && (mq.size() != 0)});
        end
    endtask

    initial begin
        logic [7:0] rv;
        int op;
        fork
            monitor();
        join_none
        repeat (3) @(posedge CLK_I);
        #1;
        chk("rst_ack", {7'b0, ACK_O}, 8'h00);
        chk("rst_dat", DAT_O, 8'h00);
        chk("rst_int", {7'b0, INT_O}, 8'h00);
        @(negedge CLK_I);
        RES_I = 1'b1;
        busy = 1'b0;

        rd_lit(2'd0, "stat_rst", 8'h01);
        rd_lit(2'd3, "cnt_rst", 8'h00);
        rd_lit(2'd2, "ctrl_rst", 8'h00);

        send(8'h1C, 0, 0, 0, 0);
        rd_lit(2'd3, "cnt_1c", 8'h01);
        rd_lit(2'd0, "stat_1c", 8'h00);
        rd_lit(2'd1, "data_1c", 8'h1C);
        wr(2'd1, 8'h00);
        rd_lit(2'd0, "stat_pop", 8'h01);
        rd_lit(2'd3, "cnt_pop", 8'h00);

        for (int k = 1; k <= 5; k++) send(8'(k), 0, 0, 0, 0);
        rd_lit(2'd3, "cnt_full", 8'h04);
        rd_lit(2'd0, "stat_ovf", 8'h06);
        for (int k = 1; k <= 4; k++) begin
            rd_lit(2'd1, "data_seq", 8'(k));
            wr(2'd1, 8'h00);
        end
        wr(2'd2, 8'h02);
        rd_lit(2'd0, "stat_drain", 8'h01);
        wr(2'd1, 8'h00);
        rd_lit(2'd0, "stat_pop_empty", 8'h01);

        send(8'h1C, 1, 0, 0, 0);
`ifdef KIA_PARITY_CHECK_EN
        rd_lit(2'd0, "stat_perr", 8'h11);
        rd_lit(2'd3, "cnt_perr", 8'h00);
`else
        rd_lit(2'd3, "cnt_par", 8'h01);
        rd_lit(2'd0, "stat_par", 8'h00);
        wr(2'd1, 8'h00);
`endif
        wr(2'd2, 8'h02);

        send(8'h33, 0, 1, 0, 0);
        rd_lit(2'd0, "stat_ferr", 8'h09);
        rd_lit(2'd3, "cnt_ferr", 8'h00);
        send(8'hF0, 0, 0, 0, 0);
        rd_lit(2'd1, "data_f0", 8'hF0);
        wr(2'd1, 8'h00);
        wr(2'd2, 8'h02);
        rd_lit(2'd0, "stat_clr", 8'h01);

        send(8'hAA, 0, 0, 4, 0);
        rd_lit(2'd0, "stat_tmo", 8'h09);
        send(8'h5A, 0, 0, 0, 0);
        rd_lit(2'd1, "data_5a", 8'h5A);
        rd_lit(2'd3, "cnt_5a", 8'h01);
        wr(2'd1, 8'h00);
        wr(2'd2, 8'h02);

        wr(2'd2, 8'h01);
        rd_lit(2'd0, "stat_ie_empty", 8'h01);
        send(8'hA1, 0, 0, 0, 0);
        chk("int_hi", {7'b0, INT_O}, 8'h01);
        rd_lit(2'd0, "stat_int", 8'h20);
        send(8'hA2, 0, 0, 0, 1);
        rd_lit(2'd3, "cnt_same", 8'h01);
        chk("int_stay", {7'b0, INT_O}, 8'h01);
        rd_lit(2'd1, "data_a2", 8'hA2);
        wr(2'd1, 8'h00);
        repeat (3) @(negedge CLK_I);
        chk("int_lo", {7'b0, INT_O}, 8'h00);

        for (int k = 0; k < 4; k++) send(8'hB0 + 8'(k), 0, 0, 0, 0);
        send(8'hB4, 0, 0, 0, 1);
        rd_lit(2'd3, "cnt_fullpop", 8'h04);
        rd_lit(2'd0, "stat_fullpop", 8'h22);
        rd_lit(2'd1, "data_b1", 8'hB1);
        wr(2'd0, 8'hFF);
        wr(2'd3, 8'hFF);
        rd_m(2'd0, "stat_ro");

        for (int it = 0; it < 40; it++) begin
            op = int'($urandom_range(0, 9));
            case (op)
                0, 1, 2, 3: begin
                    int c;
                    c = ($urandom_range(0, 9) == 0)
                        ? int'($urandom_range(1, 7)) : 0;
                    send(8'($urandom), $urandom_range(0, 7) == 0,
                         $urandom_range(0, 7) == 0, c,
                         c == 0 && $urandom_range(0, 3) == 0);
                end
                4: rd_m(2'd0, "rnd_stat");
                5: rd_m(2'd3, "rnd_cnt");
                6: rd_m(2'd1, "rnd_data");
                7: wr(2'd1, 8'($urandom));
                8: wr(2'd2, 8'($urandom_range(0, 3)));
                default: begin
                    wr(2'($urandom_range(0, 1) * 3), 8'($urandom));
                    rd_m(2'd0, "rnd_stat_ro");
                end
            endcase
        end
        rd_m(2'd0, "end_stat");
        rd_m(2'd3, "end_cnt");
        rd_m(2'd1, "end_data");
        rd_m(2'd2, "end_ctrl");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
